button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
Controller that schedules debounce sampling for a bank of raw push-button inputs on the board. It synchronizes each input, generates a shared slow sample tick, and promotes a level change only after a fixed number of consecutive agreeing samples. It emits clean levels plus one-cycle press/release pulses for downstream FSMs. It sits between the board pins and the game/control logic and replaces the per-button single-flop capture.

Parameters:
NUM_BTN, 4, number of independent button channels
TICK_DIV, 100000, clock cycles per sample tick (>=1)
STABLE_SAMPLES, 4, consecutive differing samples required to change a level (>=1)

Ports:
clock  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-high reset
btn_in  input  NUM_BTN  raw asynchronous button inputs, active-high
sample_tick  output  1  one-cycle strobe marking each sample instant
btn_level  output  NUM_BTN  debounced button level
btn_press  output  NUM_BTN  one-cycle pulse on a debounced 0->1
btn_release  output  NUM_BTN  one-cycle pulse on a debounced 1->0

Behaviour:
- Reset (async, active-high): all outputs 0, sync flops 0, tick counter 0, per-channel counters 0. Takes effect with no clock edge. Any debounce in progress is discarded.
- Synchronizer: two flops per bit; sync[i] lags btn_in[i] by 2 clocks.
- Tick divider: counter width $clog2(TICK_DIV), minimum 1 bit. Counts 0..TICK_DIV-1 and wraps to 0.
  - sample_tick is registered. It is high for exactly one cycle when the count equals TICK_DIV-1.
  - After reset deasserts, the first tick is at cycle TICK_DIV-1 (cycle 0 is the first edge after deassert). Ticks then repeat every TICK_DIV cycles.
  - TICK_DIV=1 gives a tick every cycle.
- Per-channel FSM. Each channel is independent and has its own counter cnt[i], width $clog2(STABLE_SAMPLES+1).
  - IDLE (sync==level): cnt held at 0.
  - PENDING (sync!=level): on each tick, cnt increments.
  - Any tick where sync==level returns the channel to IDLE with cnt=0. A glitch shorter than STABLE_SAMPLES ticks is therefore rejected.
  - On the tick where cnt would reach STABLE_SAMPLES:
    - btn_level[i] toggles on that edge.
    - cnt clears.
    - btn_press[i] (new level 1) or btn_release[i] (new level 0) is high for exactly the one cycle in which the new level first appears.
- Between ticks, cnt and level hold; input changes between ticks are ignored except through sync at the next tick.
- Press and release for the same channel are never high together. Different channels may pulse in the same cycle.
- Latency: a clean edge at btn_in changes btn_level on the STABLE_SAMPLES-th tick whose sampled sync value differs. Maximum delay is 2 + STABLE_SAMPLES*TICK_DIV cycles.
- No counter ever exceeds STABLE_SAMPLES; no saturation logic is needed.

Test Plan:
Bench configuration: NUM_BTN=2, TICK_DIV=4, STABLE_SAMPLES=3.
1. Reset and tick timing: assert reset for 5 cycles, then deassert with btn_in=0. Required: all outputs 0 throughout; sample_tick high at cycles 3, 7, 11, 15; btn_level stays 00.
2. Clean press: btn_in[0]=1 from cycle 0 and held. Required: btn_level[0] rises on the edge of the tick at cycle 11. btn_press[0] is high only during the cycle btn_level[0] first reads 1. btn_release and channel 1 stay 0.
3. Glitch rejection: btn_in[1] pulses high for 8 cycles (2 ticks), then returns low. Required: btn_level[1], btn_press[1] and btn_release[1] stay 0, and cnt[1] returns to 0.
4. Release: from test 2's state, drop btn_in[0] to 0. Required: btn_level[0] falls exactly 3 ticks after the first tick that samples 0. btn_release[0] is a single-cycle pulse and btn_press[0] stays 0.
5. Simultaneous channels: raise btn_in[1:0]=11 in the same cycle. Required: both levels rise and btn_press=11 in the same single cycle.
6. Reset mid-operation: hold btn_in[0]=1 for 2 ticks, assert reset between clock edges, then release reset. Required: outputs drop to 0 immediately with no edge needed. After release, btn_level[0] rises only after a fresh 3 ticks (the tick at cycle 11 counted from deassert).

Source files
------------

// File: rtl/button_conditioner.sv
// Debounces a bank of raw push-buttons: two-flop synchronizer, a shared sample
// tick, and per-channel agreement counters that emit clean levels and edge pulses.
module button_conditioner #(
   parameter int NUM_BTN        = 4,
   parameter int TICK_DIV       = 100000,
   parameter int STABLE_SAMPLES = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_BTN-1:0] btn_in,
   output logic               sample_tick,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CW = $clog2(STABLE_SAMPLES + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_SAMPLES - 1);

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } state_t;

   logic [NUM_BTN-1:0] sync1_reg;
   logic [NUM_BTN-1:0] sync2_reg;
   logic [TW-1:0]      tick_cnt_reg;
   logic               sample_tick_reg;
   logic               tick_now;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
      end else begin
         sync1_reg <= btn_in;
         sync2_reg <= sync1_reg;
      end
   end

   // The channels act on the same edge that raises sample_tick, so a level
   // change and its sample strobe become visible together.
   assign tick_now = (tick_cnt_reg == TICK_LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tick_cnt_reg    <= '0;
         sample_tick_reg <= 1'b0;
      end else begin
         tick_cnt_reg    <= tick_now ? '0 : tick_cnt_reg + 1'b1;
         sample_tick_reg <= tick_now;
      end
   end

   assign sample_tick = sample_tick_reg;

   generate
      for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
         state_t        state_reg, state_next;
         logic [CW-1:0] cnt_reg, cnt_next;
         logic          level_reg, level_next;
         logic          press_reg, press_next;
         logic          release_reg, release_next;

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               state_reg   <= IDLE;
               cnt_reg     <= '0;
               level_reg   <= 1'b0;
               press_reg   <= 1'b0;
               release_reg <= 1'b0;
            end else begin
               state_reg   <= state_next;
               cnt_reg     <= cnt_next;
               level_reg   <= level_next;
               press_reg   <= press_next;
               release_reg <= release_next;
            end
         end

         always_comb begin
            state_next   = state_reg;
            cnt_next     = cnt_reg;
            level_next   = level_reg;
            press_next   = 1'b0;
            release_next = 1'b0;
            if (tick_now) begin
               if (sync2_reg[gi] == level_reg) begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end else if (cnt_reg == CNT_LAST) begin
                  // Enough agreeing samples: commit the new level and pulse once.
                  state_next   = IDLE;
                  cnt_next     = '0;
                  level_next   = ~level_reg;
                  press_next   = ~level_reg;
                  release_next = level_reg;
               end else begin
                  state_next = PENDING;
                  cnt_next   = cnt_reg + 1'b1;
               end
            end
         end

         assign btn_level[gi]   = level_reg;
         assign btn_press[gi]   = press_reg;
         assign btn_release[gi] = release_reg;
      end
   endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a per-cycle reference model built
// from sample history and agreement counts.
module tb_button_conditioner;

   localparam int NB = 2;
   localparam int TD = 4;
   localparam int SS = 3;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [NB-1:0] btn_in = '0;
   logic          sample_tick;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] btn_press;
   logic [NB-1:0] btn_release;

   button_conditioner #(
      .NUM_BTN       (NB),
      .TICK_DIV      (TD),
      .STABLE_SAMPLES(SS)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .btn_in     (btn_in),
      .sample_tick(sample_tick),
      .btn_level  (btn_level),
      .btn_press  (btn_press),
      .btn_release(btn_release)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;
   int now      = -1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t cycle=%0d: got %0h expected %0h", nm, $time, now, act, exp);
      end
   endtask

   // Reference model: edges counted from reset release, inputs seen two edges late.
   bit [NB-1:0]   m_level, m_press, m_release;
   bit            m_tick;
   int            agree [NB];
   int            edge_idx;
   logic [NB-1:0] hist [$];
   logic [NB-1:0] m_samp;

   initial begin
      forever begin
         @(posedge clock or posedge reset);
         if (reset) begin
            m_level = '0; m_press = '0; m_release = '0; m_tick = 1'b0;
            edge_idx = 0;
            hist.delete();
            for (int c = 0; c < NB; c++) agree[c] = 0;
         end else begin
            hist.push_back(btn_in);
            m_samp = (hist.size() >= 3) ? hist[hist.size()-3] : '0;
            if (hist.size() > 3) void'(hist.pop_front());
            m_tick    = ((edge_idx % TD) == TD - 1);
            m_press   = '0;
            m_release = '0;
            if (m_tick) begin
               for (int c = 0; c < NB; c++) begin
                  if (m_samp[c] != m_level[c]) begin
                     agree[c]++;
                     if (agree[c] == SS) begin
                        m_level[c] = ~m_level[c];
                        agree[c]   = 0;
                        if (m_level[c]) m_press[c] = 1'b1;
                        else            m_release[c] = 1'b1;
                     end
                  end else begin
                     agree[c] = 0;
                  end
               end
            end
            edge_idx++;
         end
      end
   end

   always @(negedge clock) begin
      chk("model_tick",    32'(sample_tick), 32'(m_tick));
      chk("model_level",   32'(btn_level),   32'(m_level));
      chk("model_press",   32'(btn_press),   32'(m_press));
      chk("model_release", 32'(btn_release), 32'(m_release));
   end

   task automatic step();
      @(negedge clock);
      now++;
   endtask

   task automatic reset_seq(input logic [NB-1:0] v);
      reset  = 1'b1;
      btn_in = v;
      repeat (3) @(negedge clock);
      #1 reset = 1'b0;
      now = -1;
   endtask

   initial begin
      reset  = 1'b1;
      btn_in = '0;
      repeat (5) @(negedge clock);
      chk("rst_tick",  32'(sample_tick), 0);
      chk("rst_level", 32'(btn_level),   0);
      chk("rst_press", 32'(btn_press),   0);
      #1 reset = 1'b0;
      now = -1;

      // 1: tick timing with idle inputs
      for (int k = 0; k < 16; k++) begin
         step();
         chk("t1_tick",  32'(sample_tick), 32'((now % 4) == 3));
         chk("t1_level", 32'(btn_level),   0);
      end
      $display("test 1 tick timing: 16 cycles checked");

      // 2: clean press on channel 0, input high before cycle 0
      #1 reset_seq(2'b01);
      for (int k = 0; k < 14; k++) begin
         step();
         chk("t2_level", 32'(btn_level), (now >= 11) ? 32'h1 : 32'h0);
         chk("t2_press", 32'(btn_press), (now == 11) ? 32'h1 : 32'h0);
         chk("t2_rel",   32'(btn_release), 0);
      end
      $display("test 2 clean press: level rose at cycle 11");

      // 3: 8-cycle glitch on channel 1 spans only two samples
      #1 btn_in[1] = 1'b1;
      repeat (8) step();
      #1 btn_in[1] = 1'b0;
      for (int k = 0; k < 12; k++) begin
         step();
         chk("t3_ch1", 32'({btn_level[1], btn_press[1], btn_release[1]}), 0);
      end
      chk("t3_ch0_held", 32'(btn_level[0]), 1);
      $display("test 3 glitch rejection: ends at cycle %0d", now);

      // 4: release channel 0 (drop seen from edge 34, first sampling tick 39)
      #1 btn_in[0] = 1'b0;
      for (int k = 0; k < 17; k++) begin
         step();
         chk("t4_level", 32'(btn_level),   (now < 47) ? 32'h1 : 32'h0);
         chk("t4_rel",   32'(btn_release), (now == 47) ? 32'h1 : 32'h0);
         chk("t4_press", 32'(btn_press),   0);
      end
      $display("test 4 release: level fell at cycle 47");

      // 5: both channels together (first sampling tick 55)
      #1 btn_in = 2'b11;
      for (int k = 0; k < 16; k++) begin
         step();
         chk("t5_level", 32'(btn_level), (now >= 63) ? 32'h3 : 32'h0);
         chk("t5_press", 32'(btn_press), (now == 63) ? 32'h3 : 32'h0);
      end
      $display("test 5 simultaneous press: both rose at cycle 63");

      // 6: asynchronous reset in the middle of a pending release on channel 1
      #1 btn_in = 2'b01;
      repeat (8) step();
      chk("t6_pre_level", 32'(btn_level), 32'h3);
      #2 reset = 1'b1;
      #1;
      chk("t6_async_level", 32'(btn_level),   0);
      chk("t6_async_tick",  32'(sample_tick), 0);
      chk("t6_async_press", 32'(btn_press | btn_release), 0);
      repeat (2) @(negedge clock);
      #1 reset = 1'b0;
      now = -1;
      for (int k = 0; k < 14; k++) begin
         step();
         chk("t6_level", 32'(btn_level), (now >= 11) ? 32'h1 : 32'h0);
         chk("t6_press", 32'(btn_press), (now == 11) ? 32'h1 : 32'h0);
      end
      $display("test 6 reset mid-operation: fresh press at cycle 11");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
